battleship_grid: RTL and testbench

Parametrised game-state engine for Wireless Battleship. It holds our ship layout, the opponent's shots against it, and our shot history in on-chip registers. It resolves incoming shots through a ready/valid handshake and counts the ship cells still afloat. It sits between the Nios II PIOs and the radio link, replacing the fixed 8×8 software-managed board and shots registers.

---
 rtl/battleship_grid.sv | 218 +++++++++++++++++++++
 tb/tb_battleship_grid.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/battleship_grid.sv
// Battleship game-state engine: ship layout, incoming/outgoing shot planes,
// ready/valid shot resolution and a count of ship cells still afloat.
module battleship_grid #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  localparam int RW = $clog2(ROWS),
  localparam int CW = $clog2(COLS),
  localparam int NW = $clog2(ROWS * COLS + 1)
) (
  input  logic            clk_clk,
  input  logic            reset_reset,
  input  logic            clear,
  input  logic            wr_en,
  input  logic [RW-1:0]   wr_row,
  input  logic [COLS-1:0] wr_data,
  input  logic            arm,
  input  logic            shot_valid,
  input  logic [RW-1:0]   shot_row,
  input  logic [CW-1:0]   shot_col,
  output logic            shot_ready,
  output logic            res_valid,
  output logic            res_hit,
  output logic            res_repeat,
  output logic            res_err,
  input  logic            mark_valid,
  input  logic [RW-1:0]   mark_row,
  input  logic [CW-1:0]   mark_col,
  input  logic            mark_hit,
  input  logic [RW-1:0]   rd_row,
  output logic [COLS-1:0] rd_ship,
  output logic [COLS-1:0] rd_inc,
  output logic [COLS-1:0] rd_fired,
  output logic [COLS-1:0] rd_hitmark,
  output logic [NW-1:0]   remaining,
  output logic            all_sunk,
  output logic [1:0]      state_export
);

  typedef enum logic [2:0] {
    S_SETUP,
    S_COUNT,
    S_PLAY,
    S_RESOLVE,
    S_DONE
  } state_t;

  localparam logic [RW:0] ROWS_L = (RW + 1)'(ROWS);
  localparam logic [CW:0] COLS_L = (CW + 1)'(COLS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  state_t state, state_n;

  logic [COLS-1:0] ship    [ROWS];
  logic [COLS-1:0] inc_pl  [ROWS];
  logic [COLS-1:0] fired   [ROWS];
  logic [COLS-1:0] hitmark [ROWS];

  logic [RW-1:0] cnt_idx;
  logic [RW-1:0] sh_r;
  logic [CW-1:0] sh_c;

  logic [NW-1:0] rem_sum;
  logic [NW-1:0] rem_after;
  logic          shot_acc;
  logic          sh_oob;
  logic          sh_ship;
  logic          sh_inc;
  logic          fresh_hit;
  logic          wr_ok;
  logic          mark_ok;
  logic          rd_ok;

  function automatic logic [NW-1:0] popcount(input logic [COLS-1:0] v);
    logic [NW-1:0] s;
    s = '0;
    for (int i = 0; i < COLS; i++) s = s + NW'(v[i]);
    return s;
  endfunction

  assign shot_ready = (state == S_PLAY);
  assign shot_acc   = shot_valid && shot_ready;
  assign all_sunk   = (state == S_DONE);

  // Shot coordinates are range-checked before any plane lookup is trusted.
  assign sh_oob    = ({1'b0, sh_r} >= ROWS_L) || ({1'b0, sh_c} >= COLS_L);
  assign sh_ship   = !sh_oob && ship[sh_r][sh_c];
  assign sh_inc    = !sh_oob && inc_pl[sh_r][sh_c];
  assign fresh_hit = sh_ship && !sh_inc && (remaining != '0);
  assign rem_after = fresh_hit ? remaining - 1'b1 : remaining;
  assign rem_sum   = remaining + popcount(ship[cnt_idx]);

  assign wr_ok   = wr_en && ({1'b0, wr_row} < ROWS_L);
  assign mark_ok = mark_valid
                && (state == S_PLAY || state == S_RESOLVE || state == S_DONE)
                && ({1'b0, mark_row} < ROWS_L) && ({1'b0, mark_col} < COLS_L);
  assign rd_ok   = ({1'b0, rd_row} < ROWS_L);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; that is what keeps this block from inferring latches.
  always_comb begin
    state_n      = state;
    state_export = 2'd0;
    case (state)
      S_SETUP: begin
        state_export = 2'd0;
        if (arm) state_n = S_COUNT;
      end
      S_COUNT: begin
        state_export = 2'd1;
        if (cnt_idx == LAST_ROW) state_n = (rem_sum != '0) ? S_PLAY : S_DONE;
      end
      S_PLAY: begin
        state_export = 2'd2;
        if (shot_acc) state_n = S_RESOLVE;
      end
      S_RESOLVE: begin
        state_export = 2'd2;
        state_n      = (rem_after == '0) ? S_DONE : S_PLAY;
      end
      S_DONE: begin
        state_export = 2'd3;
      end
      default: state_n = S_SETUP;
    endcase
    if (clear) state_n = S_SETUP;
  end

  // NOTE: state is updated with non-blocking assignments so every register in
  // this block sees pre-edge values regardless of statement order.
  // NOTE: the planes are flop arrays, not RAM; they must be zeroed by reset and
  // by clear, so they live in the reset branch alongside the control state.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state      <= S_SETUP;
      cnt_idx    <= '0;
      sh_r       <= '0;
      sh_c       <= '0;
      remaining  <= '0;
      res_valid  <= 1'b0;
      res_hit    <= 1'b0;
      res_repeat <= 1'b0;
      res_err    <= 1'b0;
      for (int i = 0; i < ROWS; i++) begin
        ship[i]    <= '0;
        inc_pl[i]  <= '0;
        fired[i]   <= '0;
        hitmark[i] <= '0;
      end
    end else begin
      state     <= state_n;
      res_valid <= 1'b0;
      if (clear) begin
        cnt_idx   <= '0;
        remaining <= '0;
        for (int i = 0; i < ROWS; i++) begin
          ship[i]    <= '0;
          inc_pl[i]  <= '0;
          fired[i]   <= '0;
          hitmark[i] <= '0;
        end
      end else begin
        case (state)
          S_SETUP: begin
            if (wr_ok) ship[wr_row] <= wr_data;
            if (arm) begin
              cnt_idx   <= '0;
              remaining <= '0;
            end
          end
          S_COUNT: begin
            remaining <= rem_sum;
            cnt_idx   <= cnt_idx + 1'b1;
          end
          S_PLAY: begin
            if (shot_acc) begin
              sh_r <= shot_row;
              sh_c <= shot_col;
            end
          end
          S_RESOLVE: begin
            res_valid  <= 1'b1;
            res_err    <= sh_oob;
            res_repeat <= sh_inc;
            res_hit    <= sh_ship;
            remaining  <= rem_after;
            if (!sh_oob && !sh_inc) inc_pl[sh_r][sh_c] <= 1'b1;
          end
          default: ;
        endcase
        // Our own shot log is independent of incoming-shot resolution.
        if (mark_ok) begin
          fired[mark_row][mark_col] <= 1'b1;
          if (mark_hit) hitmark[mark_row][mark_col] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      rd_ship    <= '0;
      rd_inc     <= '0;
      rd_fired   <= '0;
      rd_hitmark <= '0;
    end else if (rd_ok) begin
      rd_ship    <= ship[rd_row];
      rd_inc     <= inc_pl[rd_row];
      rd_fired   <= fired[rd_row];
      rd_hitmark <= hitmark[rd_row];
    end else begin
      rd_ship    <= '0;
      rd_inc     <= '0;
      rd_fired   <= '0;
      rd_hitmark <= '0;
    end
  end

endmodule

// File: tb/tb_battleship_grid.sv
// Directed bench for battleship_grid: an 8x8 game instance (a_*) and a
// 4x12 instance (b_*) sharing clock and reset.
module tb_battleship_grid;

  logic clk_clk = 1'b0;
  logic reset_reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_clk = ~clk_clk;

  logic       a_clear, a_wr_en, a_arm, a_shot_valid, a_mark_valid, a_mark_hit;
  logic [2:0] a_wr_row, a_shot_row, a_shot_col, a_mark_row, a_mark_col, a_rd_row;
  logic [7:0] a_wr_data, a_rd_ship, a_rd_inc, a_rd_fired, a_rd_hitmark;
  logic       a_shot_ready, a_res_valid, a_res_hit, a_res_repeat, a_res_err, a_all_sunk;
  logic [6:0] a_remaining;
  logic [1:0] a_state_export;

  logic        b_clear, b_wr_en, b_arm, b_shot_valid, b_mark_valid, b_mark_hit;
  logic [1:0]  b_wr_row, b_shot_row, b_mark_row, b_rd_row;
  logic [3:0]  b_shot_col, b_mark_col;
  logic [11:0] b_wr_data, b_rd_ship, b_rd_inc, b_rd_fired, b_rd_hitmark;
  logic        b_shot_ready, b_res_valid, b_res_hit, b_res_repeat, b_res_err, b_all_sunk;
  logic [5:0]  b_remaining;
  logic [1:0]  b_state_export;

  battleship_grid #(.ROWS(8), .COLS(8)) u_a (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .clear(a_clear),
    .wr_en(a_wr_en), .wr_row(a_wr_row), .wr_data(a_wr_data), .arm(a_arm),
    .shot_valid(a_shot_valid), .shot_row(a_shot_row), .shot_col(a_shot_col),
    .shot_ready(a_shot_ready), .res_valid(a_res_valid), .res_hit(a_res_hit),
    .res_repeat(a_res_repeat), .res_err(a_res_err), .mark_valid(a_mark_valid),
    .mark_row(a_mark_row), .mark_col(a_mark_col), .mark_hit(a_mark_hit),
    .rd_row(a_rd_row), .rd_ship(a_rd_ship), .rd_inc(a_rd_inc), .rd_fired(a_rd_fired),
    .rd_hitmark(a_rd_hitmark), .remaining(a_remaining), .all_sunk(a_all_sunk),
    .state_export(a_state_export)
  );

  battleship_grid #(.ROWS(4), .COLS(12)) u_b (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .clear(b_clear),
    .wr_en(b_wr_en), .wr_row(b_wr_row), .wr_data(b_wr_data), .arm(b_arm),
    .shot_valid(b_shot_valid), .shot_row(b_shot_row), .shot_col(b_shot_col),
    .shot_ready(b_shot_ready), .res_valid(b_res_valid), .res_hit(b_res_hit),
    .res_repeat(b_res_repeat), .res_err(b_res_err), .mark_valid(b_mark_valid),
    .mark_row(b_mark_row), .mark_col(b_mark_col), .mark_hit(b_mark_hit),
    .rd_row(b_rd_row), .rd_ship(b_rd_ship), .rd_inc(b_rd_inc), .rd_fired(b_rd_fired),
    .rd_hitmark(b_rd_hitmark), .remaining(b_remaining), .all_sunk(b_all_sunk),
    .state_export(b_state_export)
  );

  // Advance one clock; outputs are then observed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic do_shot_a(input logic [2:0] r, input logic [2:0] c, input logic exp_hit,
                           input logic exp_rep, input logic exp_err,
                           input logic [6:0] exp_rem, input string name);
    int n;
    n = 0;
    while (a_shot_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (a_shot_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_timeout got %b want 1", name, a_shot_ready);
    end
    a_shot_valid = 1'b1;
    a_shot_row   = r;
    a_shot_col   = c;
    tick();
    a_shot_valid = 1'b0;
    checks++;
    if ({a_shot_ready, a_res_valid, a_state_export} !== {1'b0, 1'b0, 2'd2}) begin
      errors++;
      $display("FAIL %s_resolve ready/valid/state got %b%b/%0d want 00/2",
               name, a_shot_ready, a_res_valid, a_state_export);
    end
    tick();
    checks++;
    if ({a_res_valid, a_res_hit, a_res_repeat, a_res_err} !== {1'b1, exp_hit, exp_rep, exp_err}) begin
      errors++;
      $display("FAIL %s_result v/hit/rep/err got %b%b%b%b want 1%b%b%b", name,
               a_res_valid, a_res_hit, a_res_repeat, a_res_err, exp_hit, exp_rep, exp_err);
    end
    checks++;
    if (a_remaining !== exp_rem) begin
      errors++;
      $display("FAIL %s_remaining got %0d want %0d", name, a_remaining, exp_rem);
    end
    tick();
    checks++;
    if ({a_res_valid, a_res_hit, a_res_repeat, a_res_err} !== {1'b0, exp_hit, exp_rep, exp_err}) begin
      errors++;
      $display("FAIL %s_hold v/hit/rep/err got %b%b%b%b want 0%b%b%b", name,
               a_res_valid, a_res_hit, a_res_repeat, a_res_err, exp_hit, exp_rep, exp_err);
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    reset_reset = 1'b0;
    tick();
    checks++;
    if ({a_state_export, a_shot_ready, a_res_valid, a_all_sunk, a_remaining, a_rd_ship, a_rd_inc}
        !== '0) begin
      errors++;
      $display("FAIL reset_a state=%0d ready=%b rv=%b sunk=%b rem=%0d rd=%h/%h want all 0",
               a_state_export, a_shot_ready, a_res_valid, a_all_sunk, a_remaining,
               a_rd_ship, a_rd_inc);
    end
    checks++;
    if ({b_state_export, b_shot_ready, b_res_hit, b_res_err, b_remaining, b_rd_fired} !== '0) begin
      errors++;
      $display("FAIL reset_b state=%0d ready=%b hit=%b err=%b rem=%0d fired=%h want all 0",
               b_state_export, b_shot_ready, b_res_hit, b_res_err, b_remaining, b_rd_fired);
    end
  endtask

  task automatic test_setup_count();
    a_wr_en = 1'b1; a_wr_row = 3'd0; a_wr_data = 8'h1F;
    tick();
    a_wr_row = 3'd3; a_wr_data = 8'h07;
    tick();
    a_wr_en = 1'b0; a_rd_row = 3'd3;
    tick();
    checks++;
    if (a_rd_ship !== 8'h07) begin
      errors++;
      $display("FAIL setup_readback row3 got %h want 07", a_rd_ship);
    end
    a_arm = 1'b1;
    tick();
    a_arm = 1'b0;
    for (int i = 0; i < 8; i++) begin
      // A write attempted mid-count must be dropped.
      a_wr_en = (i == 0); a_wr_row = 3'd1; a_wr_data = 8'hFF;
      checks++;
      if (a_state_export !== 2'd1) begin
        errors++;
        $display("FAIL count_state cycle %0d got %0d want 1", i, a_state_export);
      end
      tick();
      a_wr_en = 1'b0;
    end
    checks++;
    if ({a_state_export, a_remaining, a_shot_ready} !== {2'd2, 7'd8, 1'b1}) begin
      errors++;
      $display("FAIL count_done state/rem/ready got %0d/%0d/%b want 2/8/1",
               a_state_export, a_remaining, a_shot_ready);
    end
    a_rd_row = 3'd1;
    tick();
    checks++;
    if (a_rd_ship !== 8'h00) begin
      errors++;
      $display("FAIL count_write_ignored row1 got %h want 00", a_rd_ship);
    end
  endtask

  task automatic test_shots();
    do_shot_a(3'd0, 3'd4, 1'b1, 1'b0, 1'b0, 7'd7, "hit_0_4");
    do_shot_a(3'd0, 3'd5, 1'b0, 1'b0, 1'b0, 7'd7, "miss_0_5");
    do_shot_a(3'd0, 3'd4, 1'b1, 1'b1, 1'b0, 7'd7, "repeat_0_4");
  endtask

  task automatic test_back_to_back();
    a_shot_valid = 1'b1; a_shot_row = 3'd0; a_shot_col = 3'd0;
    tick();
    a_shot_col = 3'd1;
    checks++;
    if (a_shot_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_busy ready got %b want 0", a_shot_ready);
    end
    tick();
    checks++;
    if ({a_res_valid, a_res_hit, a_shot_ready, a_remaining} !== {1'b1, 1'b1, 1'b1, 7'd6}) begin
      errors++;
      $display("FAIL b2b_first v/hit/ready/rem got %b/%b/%b/%0d want 1/1/1/6",
               a_res_valid, a_res_hit, a_shot_ready, a_remaining);
    end
    tick();
    a_shot_valid = 1'b0;
    checks++;
    if (a_res_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap res_valid got %b want 0", a_res_valid);
    end
    tick();
    checks++;
    if ({a_res_valid, a_res_hit, a_remaining} !== {1'b1, 1'b1, 7'd5}) begin
      errors++;
      $display("FAIL b2b_second v/hit/rem got %b/%b/%0d want 1/1/5",
               a_res_valid, a_res_hit, a_remaining);
    end
    tick();
  endtask

  task automatic test_sink_and_clear();
    do_shot_a(3'd0, 3'd2, 1'b1, 1'b0, 1'b0, 7'd4, "sink_0_2");
    do_shot_a(3'd0, 3'd3, 1'b1, 1'b0, 1'b0, 7'd3, "sink_0_3");
    do_shot_a(3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 7'd2, "sink_3_0");
    do_shot_a(3'd3, 3'd1, 1'b1, 1'b0, 1'b0, 7'd1, "sink_3_1");
    do_shot_a(3'd3, 3'd2, 1'b1, 1'b0, 1'b0, 7'd0, "sink_3_2");
    checks++;
    if ({a_state_export, a_all_sunk, a_shot_ready, a_remaining} !== {2'd3, 1'b1, 1'b0, 7'd0}) begin
      errors++;
      $display("FAIL done state/sunk/ready/rem got %0d/%b/%b/%0d want 3/1/0/0",
               a_state_export, a_all_sunk, a_shot_ready, a_remaining);
    end
    a_rd_row = 3'd0;
    tick();
    checks++;
    if ({a_rd_ship, a_rd_inc} !== {8'h1F, 8'h3F}) begin
      errors++;
      $display("FAIL done_planes row0 ship/inc got %h/%h want 1f/3f", a_rd_ship, a_rd_inc);
    end
    a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
    checks++;
    if ({a_state_export, a_all_sunk, a_shot_ready, a_remaining} !== '0) begin
      errors++;
      $display("FAIL clear state/sunk/ready/rem got %0d/%b/%b/%0d want 0/0/0/0",
               a_state_export, a_all_sunk, a_shot_ready, a_remaining);
    end
    tick();
    checks++;
    if ({a_rd_ship, a_rd_inc} !== 16'h0000) begin
      errors++;
      $display("FAIL clear_planes row0 ship/inc got %h/%h want 00/00", a_rd_ship, a_rd_inc);
    end
  endtask

  task automatic test_mark_and_range();
    b_wr_en = 1'b1; b_wr_row = 2'd2; b_wr_data = 12'h801;
    tick();
    b_wr_en = 1'b0; b_arm = 1'b1;
    tick();
    b_arm = 1'b0;
    repeat (4) tick();
    checks++;
    if ({b_state_export, b_remaining} !== {2'd2, 6'd2}) begin
      errors++;
      $display("FAIL b_count state/rem got %0d/%0d want 2/2", b_state_export, b_remaining);
    end
    b_rd_row = 2'd2;
    b_shot_valid = 1'b1; b_shot_row = 2'd2; b_shot_col = 4'd11;
    b_mark_valid = 1'b1; b_mark_row = 2'd2; b_mark_col = 4'd11; b_mark_hit = 1'b1;
    tick();
    b_shot_valid = 1'b0; b_mark_valid = 1'b0;
    tick();
    checks++;
    if ({b_res_valid, b_res_hit, b_res_err, b_remaining} !== {1'b1, 1'b1, 1'b0, 6'd1}) begin
      errors++;
      $display("FAIL b_shot_with_mark v/hit/err/rem got %b/%b/%b/%0d want 1/1/0/1",
               b_res_valid, b_res_hit, b_res_err, b_remaining);
    end
    checks++;
    if ({b_rd_fired, b_rd_hitmark} !== {12'h800, 12'h800}) begin
      errors++;
      $display("FAIL b_mark_readout fired/hitmark got %h/%h want 800/800",
               b_rd_fired, b_rd_hitmark);
    end
    tick();
    checks++;
    if (b_rd_inc !== 12'h800) begin
      errors++;
      $display("FAIL b_inc_readout got %h want 800", b_rd_inc);
    end
    b_shot_valid = 1'b1; b_shot_row = 2'd1; b_shot_col = 4'd13;
    tick();
    b_shot_valid = 1'b0;
    tick();
    checks++;
    if ({b_res_valid, b_res_err, b_res_hit, b_res_repeat, b_remaining}
        !== {1'b1, 1'b1, 1'b0, 1'b0, 6'd1}) begin
      errors++;
      $display("FAIL b_out_of_range v/err/hit/rep/rem got %b/%b/%b/%b/%0d want 1/1/0/0/1",
               b_res_valid, b_res_err, b_res_hit, b_res_repeat, b_remaining);
    end
    tick();
    b_shot_valid = 1'b1; b_shot_row = 2'd2; b_shot_col = 4'd0;
    tick();
    b_shot_valid = 1'b0; b_clear = 1'b1;
    tick();
    b_clear = 1'b0;
    checks++;
    if ({b_res_valid, b_state_export, b_remaining} !== '0) begin
      errors++;
      $display("FAIL b_clear_in_resolve v/state/rem got %b/%0d/%0d want 0/0/0",
               b_res_valid, b_state_export, b_remaining);
    end
    tick();
    checks++;
    if ({b_rd_ship, b_rd_fired, b_rd_hitmark} !== '0) begin
      errors++;
      $display("FAIL b_clear_planes ship/fired/hitmark got %h/%h/%h want 0/0/0",
               b_rd_ship, b_rd_fired, b_rd_hitmark);
    end
  endtask

  task automatic test_reset_mid_play();
    a_wr_en = 1'b1; a_wr_row = 3'd0; a_wr_data = 8'h01;
    tick();
    a_wr_en = 1'b0; a_arm = 1'b1; a_rd_row = 3'd0;
    tick();
    a_arm = 1'b0;
    repeat (8) tick();
    checks++;
    if ({a_state_export, a_remaining, a_rd_ship} !== {2'd2, 7'd1, 8'h01}) begin
      errors++;
      $display("FAIL rearm state/rem/rd got %0d/%0d/%h want 2/1/01",
               a_state_export, a_remaining, a_rd_ship);
    end
    #2 reset_reset = 1'b1;
    #1;
    checks++;
    if ({a_state_export, a_remaining, a_shot_ready, a_all_sunk, a_res_valid, a_rd_ship} !== '0) begin
      errors++;
      $display("FAIL async_reset state/rem/ready/sunk/rv/rd got %0d/%0d/%b/%b/%b/%h want 0",
               a_state_export, a_remaining, a_shot_ready, a_all_sunk, a_res_valid, a_rd_ship);
    end
    tick();
    reset_reset = 1'b0;
    tick();
  endtask

  initial begin
    a_clear = 0; a_wr_en = 0; a_arm = 0; a_shot_valid = 0; a_mark_valid = 0; a_mark_hit = 0;
    a_wr_row = 0; a_shot_row = 0; a_shot_col = 0; a_mark_row = 0; a_mark_col = 0;
    a_rd_row = 0; a_wr_data = 0;
    b_clear = 0; b_wr_en = 0; b_arm = 0; b_shot_valid = 0; b_mark_valid = 0; b_mark_hit = 0;
    b_wr_row = 0; b_shot_row = 0; b_shot_col = 0; b_mark_row = 0; b_mark_col = 0;
    b_rd_row = 0; b_wr_data = 0;
    test_reset();
    test_setup_count();
    test_shots();
    test_back_to_back();
    test_sink_and_clear();
    test_mark_and_range();
    test_reset_mid_play();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
